// File: rtl/iowrite_disp.sv
// CPU-written LED and 8-digit seven-segment output block with scan multiplexing.
// Optional leading-zero blanking: define IOWRITE_BLANK_LEADING_ZERO_EN.
module iowrite_disp #(
    parameter int SCAN_DIV = 50000,
    parameter int DIGITS   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iow,
    input  logic [1:0]  addr_low,
    input  logic [15:0] wdata,
    output logic [15:0] led,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DIGITS);
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

    logic [31:0]   seg_data;
    logic [CW-1:0] div_cnt;
    logic [DW-1:0] digit;
    logic [3:0]    nib;
    logic [7:0]    glyph;
    logic [7:0]    seg_next;
    logic [4:0]    shamt;

    always_comb begin
        shamt = {digit, 2'b00};
        nib   = seg_data[shamt +: 4];
    end

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp always off
    always_comb begin
        glyph = 8'hFF;
        unique case (nib)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            4'hF: glyph = 8'h8E;
        endcase
    end

`ifdef IOWRITE_BLANK_LEADING_ZERO_EN
    logic blank;

    // Digit 0 always lit so an all-zero value still reads "0"
    always_comb begin
        blank    = (digit != '0) && ((seg_data >> shamt) == 32'd0);
        seg_next = blank ? 8'hFF : glyph;
    end
`else
    always_comb begin
        seg_next = glyph;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            led      <= 16'h0000;
            seg_data <= 32'h0000_0000;
            div_cnt  <= '0;
            digit    <= '0;
            seg_an   <= 8'hFE;
            seg_out  <= 8'hC0;
        end else begin
            if (iow) begin
                unique case (addr_low)
                    2'b00:   led <= wdata;
                    2'b10:   seg_data[15:0] <= wdata;
                    2'b11:   seg_data[31:16] <= wdata;
                    default: ;
                endcase
            end
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                digit   <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            seg_an  <= ~(8'd1 << digit);
            seg_out <= seg_next;
        end
    end

endmodule

// File: tb/tb_iowrite_disp.sv
// Self-checking bench for iowrite_disp with a cycle-count reference model.
// Blanking expectations follow IOWRITE_BLANK_LEADING_ZERO_EN when defined.
module tb_iowrite_disp;

    localparam int SD = 4;

    logic        clk;
    logic        reset;
    logic        iow;
    logic [1:0]  addr_low;
    logic [15:0] wdata;
    logic [15:0] led;
    logic [7:0]  seg_an;
    logic [7:0]  seg_out;

    int checks;
    int failures;

    logic [15:0] m_led;
    logic [31:0] m_seg;
    int          m_n;
    logic [15:0] exp_led;
    logic [7:0]  exp_an;
    logic [7:0]  exp_seg;

    logic [7:0] gly [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                             8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83,
                             8'hC6, 8'hA1, 8'h86, 8'h8E};

    iowrite_disp #(.SCAN_DIV(SD), .DIGITS(8)) dut (
        .clock    (clk),
        .reset    (reset),
        .iow      (iow),
        .addr_low (addr_low),
        .wdata    (wdata),
        .led      (led),
        .seg_an   (seg_an),
        .seg_out  (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_glyph(input logic [31:0] s, input int d);
        logic [31:0] sh;
        sh = s >> (4 * d);
`ifdef IOWRITE_BLANK_LEADING_ZERO_EN
        if (d > 0 && sh == 32'd0) return 8'hFF;
`endif
        return gly[sh[3:0]];
    endfunction

    function automatic int an_digit(input logic [7:0] an);
        for (int d = 0; d < 8; d++)
            if (an == ~(8'd1 << d)) return d;
        return -1;
    endfunction

    // Outputs after an edge show the digit/data held before that edge
    task automatic tick(input logic r, input logic w,
                        input logic [1:0] a, input logic [15:0] d);
        int dg;
        reset = r; iow = w; addr_low = a; wdata = d;
        @(posedge clk);
        if (r) begin
            m_led = '0; m_seg = '0; m_n = 0;
            exp_an = 8'hFE; exp_seg = 8'hC0;
        end else begin
            dg = (m_n / SD) % 8;
            exp_an = ~(8'd1 << dg);
            exp_seg = exp_glyph(m_seg, dg);
            if (w) begin
                if (a == 2'b00) m_led = d;
                else if (a == 2'b10) m_seg[15:0] = d;
                else if (a == 2'b11) m_seg[31:16] = d;
            end
            m_n++;
        end
        exp_led = m_led;
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 2'b00, 16'h0);
            checks++;
            if (led !== 16'h0000 || seg_an !== 8'hFE || seg_out !== 8'hC0) begin
                failures++;
                $display("FAIL reset_hold led=%h an=%h seg=%h exp 0000/FE/C0",
                         led, seg_an, seg_out);
            end
        end
        for (int k = 1; k <= 40; k++) begin
            tick(0, 0, 2'b00, 16'h0);
            checks++;
            if (seg_an !== exp_an || seg_out !== exp_seg) begin
                failures++;
                $display("FAIL reset_scan k=%0d an=%h seg=%h exp %h/%h",
                         k, seg_an, seg_out, exp_an, exp_seg);
            end
            if (k == 29 || k == 33) begin
                checks++;
                if (seg_an !== ((k == 29) ? 8'h7F : 8'hFE)) begin
                    failures++;
                    $display("FAIL scan_wrap k=%0d an=%h", k, seg_an);
                end
            end
        end
    endtask

    task automatic test_led_write;
        tick(0, 1, 2'b00, 16'hA5C3);
        checks++;
        if (led !== 16'hA5C3) begin
            failures++;
            $display("FAIL led_write got=%h exp=A5C3", led);
        end
        tick(0, 1, 2'b01, 16'hFFFF);
        for (int k = 0; k < 33; k++) begin
            tick(0, 0, 2'b00, 16'h0);
            checks++;
            if (led !== 16'hA5C3 || seg_out !== exp_seg || seg_an !== exp_an) begin
                failures++;
                $display("FAIL reserved_addr led=%h an=%h seg=%h exp A5C3/%h/%h",
                         led, seg_an, seg_out, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_seg_write;
        logic [7:0] tbl [8];
        int d;
        tbl = '{8'h83, 8'h88, 8'h90, 8'h80, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
`ifdef IOWRITE_BLANK_LEADING_ZERO_EN
        tbl[7] = 8'hFF;
`endif
        tick(0, 1, 2'b10, 16'h89AB);
        tick(0, 1, 2'b11, 16'h0123);
        tick(0, 0, 2'b00, 16'h0);
        for (int k = 0; k < 34; k++) begin
            tick(0, 0, 2'b00, 16'h0);
            d = an_digit(seg_an);
            checks++;
            if (d < 0 || seg_out !== tbl[d] || seg_an !== exp_an) begin
                failures++;
                $display("FAIL seg_glyph an=%h seg=%h exp_an=%h exp_seg=%h",
                         seg_an, seg_out, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_collision;
        int guard;
        guard = 0;
        while ((m_n % (8 * SD)) != (8 * SD - 1) && guard < 64) begin
            tick(0, 0, 2'b00, 16'h0);
            guard++;
        end
        checks++;
        if (guard >= 64) begin
            failures++;
            $display("FAIL collision_align timeout n=%0d", m_n);
        end
        tick(0, 1, 2'b10, 16'h000F);
        checks++;
        if (seg_an !== 8'h7F || seg_out !== exp_seg) begin
            failures++;
            $display("FAIL collision_old an=%h seg=%h exp 7F/%h",
                     seg_an, seg_out, exp_seg);
        end
        tick(0, 0, 2'b00, 16'h0);
        checks++;
        if (seg_an !== 8'hFE || seg_out !== 8'h8E) begin
            failures++;
            $display("FAIL collision_new an=%h seg=%h exp FE/8E", seg_an, seg_out);
        end
    endtask

    task automatic test_midscan_reset;
        int guard;
        guard = 0;
        while (((m_n / SD) % 8) != 5 && guard < 64) begin
            tick(0, 0, 2'b00, 16'h0);
            guard++;
        end
        tick(0, 0, 2'b00, 16'h0);
        tick(1, 0, 2'b00, 16'h0);
        checks++;
        if (led !== 16'h0 || seg_an !== 8'hFE || seg_out !== 8'hC0) begin
            failures++;
            $display("FAIL midscan_reset led=%h an=%h seg=%h exp 0000/FE/C0",
                     led, seg_an, seg_out);
        end
        for (int k = 1; k <= 5; k++) begin
            tick(0, 0, 2'b00, 16'h0);
            checks++;
            if (seg_an !== ((k <= 4) ? 8'hFE : 8'hFD)) begin
                failures++;
                $display("FAIL midscan_restart k=%0d an=%h", k, seg_an);
            end
        end
    endtask

    task automatic test_random;
        logic r;
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 63) == 0);
            tick(r, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 16'($urandom));
            checks++;
            if (led !== exp_led || seg_an !== exp_an || seg_out !== exp_seg) begin
                failures++;
                $display("FAIL random k=%0d led=%h an=%h seg=%h exp %h/%h/%h",
                         k, led, seg_an, seg_out, exp_led, exp_an, exp_seg);
            end
        end
    endtask

`ifdef IOWRITE_BLANK_LEADING_ZERO_EN
    task automatic test_blank;
        logic [7:0] tbl [8];
        int d;
        tbl = '{8'hC0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tick(0, 1, 2'b10, 16'h0120);
        tick(0, 1, 2'b11, 16'h0000);
        tick(0, 0, 2'b00, 16'h0);
        for (int k = 0; k < 33; k++) begin
            tick(0, 0, 2'b00, 16'h0);
            d = an_digit(seg_an);
            checks++;
            if (d < 0 || seg_out !== tbl[d]) begin
                failures++;
                $display("FAIL blank_120 an=%h seg=%h", seg_an, seg_out);
            end
        end
        tick(0, 1, 2'b10, 16'h0000);
        tick(0, 0, 2'b00, 16'h0);
        for (int k = 0; k < 33; k++) begin
            tick(0, 0, 2'b00, 16'h0);
            d = an_digit(seg_an);
            checks++;
            if (d < 0 || seg_out !== ((d == 0) ? 8'hC0 : 8'hFF)) begin
                failures++;
                $display("FAIL blank_zero an=%h seg=%h", seg_an, seg_out);
            end
        end
    endtask
`endif

    initial begin
        checks = 0; failures = 0;
        m_led = '0; m_seg = '0; m_n = 0;
        exp_led = '0; exp_an = 8'hFE; exp_seg = 8'hC0;
        reset = 1'b1; iow = 1'b0; addr_low = 2'b00; wdata = 16'h0;
        test_reset();
        test_led_write();
        test_seg_write();
        test_collision();
        test_midscan_reset();
`ifdef IOWRITE_BLANK_LEADING_ZERO_EN
        test_blank();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
